// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   addr_i/re_i/we_i/din_i   CPU request (we_i is a byte mask, bit 3 = byte [31:24])
//   dout_o, stall_o      CPU read data and pipeline freeze
//   mem_req_*            memory request channel (valid/ready handshake)
//   mem_resp_valid_i/mem_resp_data_i  refill beats, word 0 first
module dcache_ctrl #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        re_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic        stall_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_req_rnw_o,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_data_o,
  output logic [3:0]  mem_req_mask_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_DONE,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    data_mem [LINES*WORDS];
  logic [TW-1:0]  tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  // Request captured at acceptance; held for the whole miss/write sequence.
  logic [31:2]    addr_q;
  logic [3:0]     we_q;
  logic [31:0]    din_q;
  logic           rd_pend_q;
  logic [TW-1:0]  tag_rd_q;
  logic           valid_rd_q;
  logic [31:0]    out_q;
  logic [OW-1:0]  beat_q;

  logic           accept;
  logic           hit;
  logic           last_beat;
  logic [31:0]    merged;

  logic [OW-1:0]  off_i, off_q;
  logic [IW-1:0]  idx_i, idx_q;
  logic [TW-1:0]  tag_q;
  logic           unused_addr;

  assign off_i = addr_i[2 +: OW];
  assign idx_i = addr_i[2+OW +: IW];
  assign off_q = addr_q[2 +: OW];
  assign idx_q = addr_q[2+OW +: IW];
  assign tag_q = addr_q[31 -: TW];
  assign unused_addr = ^addr_i[1:0];

  assign hit       = valid_rd_q && (tag_rd_q == tag_q);
  assign last_beat = mem_resp_valid_i && (beat_q == OW'(WORDS-1));
  assign dout_o    = out_q;

  // out_q still holds the cached word read at acceptance, so it is the merge base.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = we_q[b] ? din_q[8*b +: 8] : out_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    stall_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_rnw_o   = 1'b0;
    mem_req_addr_o  = 32'h0;
    mem_req_data_o  = 32'h0;
    mem_req_mask_o  = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (rd_pend_q && !hit) begin
          // Miss detected on the registered lookup; the CPU holds its request.
          stall_o = 1'b1;
          state_d = S_REFILL_REQ;
        end else if (we_i != 4'h0) begin
          accept  = 1'b1;
          state_d = S_WRITE;
        end else if (re_i) begin
          accept  = 1'b1;
        end
      end
      S_REFILL_REQ: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        mem_req_rnw_o   = 1'b1;
        mem_req_addr_o  = {addr_q[31:2+OW], {(2+OW){1'b0}}};
        if (mem_req_ready_i) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        stall_o = 1'b1;
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_WRITE: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {addr_q[31:2], 2'b00};
        mem_req_data_o  = din_q;
        mem_req_mask_o  = we_q;
        if (mem_req_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      rd_pend_q <= 1'b0;
      beat_q    <= '0;
      out_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= accept && re_i && (we_i == 4'h0);
      if (accept) begin
        out_q <= data_mem[{idx_i, off_i}];
      end else if (state_q == S_REFILL_WAIT && mem_resp_valid_i && beat_q == off_q) begin
        // Forward the requested word so DONE can present it without a re-read.
        out_q <= mem_resp_data_i;
      end
      if (state_q == S_REFILL_WAIT && mem_resp_valid_i) begin
        beat_q <= beat_q + 1'b1;
        if (last_beat) valid_q[idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= addr_i[31:2];
      we_q       <= we_i;
      din_q      <= din_i;
      tag_rd_q   <= tag_mem[idx_i];
      valid_rd_q <= valid_q[idx_i];
    end
    if (!rst) begin
      if (state_q == S_REFILL_WAIT && mem_resp_valid_i) begin
        data_mem[{idx_q, beat_q}] <= mem_resp_data_i;
        if (last_beat) tag_mem[idx_q] <= tag_q;
      end
      if (state_q == S_WRITE && mem_req_ready_i && hit) begin
        data_mem[{idx_q, off_q}] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic        mreq_valid;
  logic        mreq_ready;
  logic        mreq_rnw;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_data;
  logic [3:0]  mreq_mask;
  logic        mresp_valid;
  logic [31:0] mresp_data;

  int total;
  int bad;

  logic [31:0] a_line [4];
  logic [31:0] b_line [4];

  dcache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .addr_i           (addr),
    .re_i             (re),
    .we_i             (we),
    .din_i            (din),
    .dout_o           (dout),
    .stall_o          (stall),
    .mem_req_valid_o  (mreq_valid),
    .mem_req_ready_i  (mreq_ready),
    .mem_req_rnw_o    (mreq_rnw),
    .mem_req_addr_o   (mreq_addr),
    .mem_req_data_o   (mreq_data),
    .mem_req_mask_o   (mreq_mask),
    .mem_resp_valid_i (mresp_valid),
    .mem_resp_data_i  (mresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [31:0] a);
    addr = a; re = 1'b1; we = 4'h0; din = 32'h0;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    addr = a; re = 1'b0; we = m; din = d;
  endtask

  task automatic cpu_idle;
    re = 1'b0; we = 4'h0;
  endtask

  task automatic send_line(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      mresp_valid = 1'b1;
      mresp_data  = w[i];
      tick;
    end
    mresp_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    a_line[0] = 32'hA0A0_0000; a_line[1] = 32'hA1A1_1111;
    a_line[2] = 32'hA2A2_2222; a_line[3] = 32'hA3A3_3333;
    b_line[0] = 32'hB0B0_0000; b_line[1] = 32'hB1B1_1111;
    b_line[2] = 32'hB2B2_2222; b_line[3] = 32'hB3B3_3333;

    rst = 1'b1; addr = 32'h0; re = 1'b0; we = 4'h0; din = 32'h0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_data = 32'h0;
    tick;
    tick;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mreq_valid", {31'h0, mreq_valid}, 32'h0);
    chk("rst_dout", dout, 32'h0);
    rst = 1'b0;

    // Cold read miss and refill
    cpu_rd(32'h1000_0040);
    tick;
    chk("miss_stall_n1", {31'h0, stall}, 32'h1);
    chk("miss_no_req_n1", {31'h0, mreq_valid}, 32'h0);
    tick;
    chk("refill_req_valid", {31'h0, mreq_valid}, 32'h1);
    chk("refill_req_rnw", {31'h0, mreq_rnw}, 32'h1);
    chk("refill_req_addr", mreq_addr, 32'h1000_0040);
    mreq_ready  = 1'b1;
    mresp_valid = 1'b1;
    mresp_data  = 32'hDEAD_DEAD;  // stray beat outside REFILL_WAIT
    tick;
    mreq_ready = 1'b0;
    chk("refill_wait_no_req", {31'h0, mreq_valid}, 32'h0);
    chk("refill_wait_stall", {31'h0, stall}, 32'h1);
    send_line(a_line[0], a_line[1], a_line[2], a_line[3]);
    chk("done_stall", {31'h0, stall}, 32'h0);
    chk("done_dout", dout, a_line[0]);
    tick;

    // Hit on the freshly filled line
    cpu_rd(32'h1000_0044);
    tick;
    chk("hit_stall", {31'h0, stall}, 32'h0);
    chk("hit_dout", dout, a_line[1]);
    chk("hit_no_req", {31'h0, mreq_valid}, 32'h0);

    // Write hit with ready held low three cycles
    cpu_wr(32'h1000_0044, 4'b0011, 32'h0000_BEEF);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("wr_stall", {31'h0, stall}, 32'h1);
      chk("wr_valid", {31'h0, mreq_valid}, 32'h1);
      chk("wr_rnw", {31'h0, mreq_rnw}, 32'h0);
      chk("wr_addr", mreq_addr, 32'h1000_0044);
      chk("wr_data", mreq_data, 32'h0000_BEEF);
      chk("wr_mask", {28'h0, mreq_mask}, 32'h3);
      if (k == 3) mreq_ready = 1'b1;
      tick;
    end
    mreq_ready = 1'b0;
    chk("wr_stall_fall", {31'h0, stall}, 32'h0);
    chk("wr_valid_fall", {31'h0, mreq_valid}, 32'h0);

    // Read back merged word
    cpu_rd(32'h1000_0044);
    tick;
    chk("merged_stall", {31'h0, stall}, 32'h0);
    chk("merged_dout", dout, 32'hA1A1_BEEF);

    // Back-to-back hits
    cpu_rd(32'h1000_0040);
    tick;
    chk("b2b_0_dout", dout, a_line[0]);
    chk("b2b_0_stall", {31'h0, stall}, 32'h0);
    cpu_rd(32'h1000_0048);
    tick;
    chk("b2b_2_dout", dout, a_line[2]);
    chk("b2b_2_stall", {31'h0, stall}, 32'h0);
    cpu_rd(32'h1000_004C);
    tick;
    chk("b2b_3_dout", dout, a_line[3]);
    chk("b2b_3_stall", {31'h0, stall}, 32'h0);

    // Aliasing line evicts the first
    cpu_rd(32'h1000_0440);
    tick;
    chk("alias_miss_stall", {31'h0, stall}, 32'h1);
    tick;
    chk("alias_req_addr", mreq_addr, 32'h1000_0440);
    mreq_ready = 1'b1;
    tick;
    mreq_ready = 1'b0;
    send_line(b_line[0], b_line[1], b_line[2], b_line[3]);
    chk("alias_done_dout", dout, b_line[0]);
    chk("alias_done_stall", {31'h0, stall}, 32'h0);
    tick;
    cpu_rd(32'h1000_0040);
    tick;
    chk("evicted_miss_stall", {31'h0, stall}, 32'h1);

    // Reset during the second refill beat
    tick;
    chk("rerefill_req_addr", mreq_addr, 32'h1000_0040);
    mreq_ready = 1'b1;
    tick;
    mreq_ready  = 1'b0;
    mresp_valid = 1'b1;
    mresp_data  = a_line[0];
    tick;
    mresp_data = a_line[1];
    rst = 1'b1;
    cpu_idle;
    tick;
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    chk("midrst_mreq_valid", {31'h0, mreq_valid}, 32'h0);
    chk("midrst_dout", dout, 32'h0);
    rst = 1'b0;
    mresp_data = a_line[2];  // late beat after reset
    cpu_rd(32'h1000_0040);
    tick;
    mresp_valid = 1'b0;
    chk("postrst_miss_stall", {31'h0, stall}, 32'h1);
    tick;
    chk("postrst_req_valid", {31'h0, mreq_valid}, 32'h1);
    chk("postrst_req_addr", mreq_addr, 32'h1000_0040);
    mreq_ready = 1'b1;
    tick;
    mreq_ready = 1'b0;
    send_line(a_line[0], a_line[1], a_line[2], a_line[3]);
    chk("postrst_done_dout", dout, a_line[0]);
    tick;
    cpu_idle;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
